dm_port_arbiter: RTL and testbench

Two-requester arbiter and access sequencer for the single-port data memory. It sits between the CPU MEM stage (port 0) and the debug/DMA bridge (port 1) on one side and the DM on the other. It grants one access per cycle in round-robin order, and registers the granted request into an access stage. It generates DM byte enables and write-data lanes from access size and address, then returns sign- or zero-extended load data one cycle after the DM access.

---
 rtl/dm_port_arbiter.sv | 238 +++++++++++++++++++++++
 tb/tb_dm_port_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_port_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the single-port data memory.
// Optional misalignment checking is compiled in with `define DM_ARB_ALIGN_CHECK_EN.
module dm_port_arbiter (
  input  logic        clk,
  input  logic        clr,

  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wd,
  input  logic [1:0]  m0_size,
  input  logic        m0_sext,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,

  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wd,
  input  logic [1:0]  m1_size,
  input  logic        m1_sext,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,

  output logic        dm_we,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wd,
  input  logic [31:0] dm_rd,

  output logic        dbg_state
);

  // Handshake: a port's request (req plus fields) is taken at the rising edge
  // where its gnt is high; the requester must drop or replace it the next cycle.
  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_last;

  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_any_gnt;
  logic        w_sel_we;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wd;
  logic [1:0]  w_sel_size;
  logic        w_sel_sext;
  logic        w_sel_mis;

  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wd;
  logic [1:0]  r_size;
  logic        r_sext;
  logic        r_port;
  logic        r_mis;

  logic [3:0]  w_be_raw;
  logic [31:0] w_wd_lane;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;
  logic        w_in_access;

  logic        r_rvalid0;
  logic        r_rvalid1;
  logic [31:0] r_rdata;

  // Arbitration: r_last names the port granted most recently; it loses a tie.
  // A grant during clr is suppressed so the requester simply keeps asking.
  always_comb begin
    w_gnt0    = m0_req & (~m1_req | r_last) & ~clr;
    w_gnt1    = m1_req & (~m0_req | ~r_last) & ~clr;
    w_any_gnt = w_gnt0 | w_gnt1;
  end

  always_comb begin
    w_sel_we   = m0_we;
    w_sel_addr = m0_addr;
    w_sel_wd   = m0_wd;
    w_sel_size = m0_size;
    w_sel_sext = m0_sext;
    if (w_gnt1) begin
      w_sel_we   = m1_we;
      w_sel_addr = m1_addr;
      w_sel_wd   = m1_wd;
      w_sel_size = m1_size;
      w_sel_sext = m1_sext;
    end
  end

`ifdef DM_ARB_ALIGN_CHECK_EN
  always_comb begin
    w_sel_mis = 1'b0;
    if (w_sel_size == 2'b01)
      w_sel_mis = w_sel_addr[0];
    else if (w_sel_size[1])
      w_sel_mis = (w_sel_addr[1:0] != 2'b00);
  end
`else
  assign w_sel_mis = 1'b0;
`endif

  always_comb begin
    w_state_nxt = IDLE;
    if (w_any_gnt)
      w_state_nxt = ACCESS;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (w_any_gnt)
        r_last <= w_gnt1;
    end
  end

  // Latched request; fields hold while idle so dm_addr/dm_wd keep their last value.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_we   <= 1'b0;
      r_addr <= 32'h0;
      r_wd   <= 32'h0;
      r_size <= 2'b00;
      r_sext <= 1'b0;
      r_port <= 1'b0;
      r_mis  <= 1'b0;
    end else if (w_any_gnt) begin
      r_we   <= w_sel_we;
      r_addr <= w_sel_addr;
      r_wd   <= w_sel_wd;
      r_size <= w_sel_size;
      r_sext <= w_sel_sext;
      r_port <= w_gnt1;
      r_mis  <= w_sel_mis;
    end
  end

  always_comb begin
    w_be_raw  = 4'b1111;
    w_wd_lane = r_wd;
    case (r_size)
      2'b00: begin
        w_be_raw  = 4'b0001 << r_addr[1:0];
        w_wd_lane = {4{r_wd[7:0]}};
      end
      2'b01: begin
        w_be_raw  = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wd_lane = {2{r_wd[15:0]}};
      end
      default: begin
        w_be_raw  = 4'b1111;
        w_wd_lane = r_wd;
      end
    endcase
  end

  // clr in the access cycle cancels the pending write at that same edge.
  assign w_in_access = (r_state == ACCESS) & ~clr;

  always_comb begin
    dm_we   = w_in_access & r_we & ~r_mis;
    dm_be   = (w_in_access & ~r_mis) ? w_be_raw : 4'b0000;
    dm_addr = r_addr;
    dm_wd   = w_wd_lane;
  end

  always_comb begin
    w_byte = dm_rd[7:0];
    case (r_addr[1:0])
      2'b00:   w_byte = dm_rd[7:0];
      2'b01:   w_byte = dm_rd[15:8];
      2'b10:   w_byte = dm_rd[23:16];
      default: w_byte = dm_rd[31:24];
    endcase
    w_half = r_addr[1] ? dm_rd[31:16] : dm_rd[15:0];
    case (r_size)
      2'b00:   w_ext = {{24{r_sext & w_byte[7]}}, w_byte};
      2'b01:   w_ext = {{16{r_sext & w_half[15]}}, w_half};
      default: w_ext = dm_rd;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata   <= 32'h0;
    end else if (r_state == ACCESS) begin
      r_rvalid0 <= ~r_port;
      r_rvalid1 <= r_port;
      r_rdata   <= (r_we | r_mis) ? 32'h0 : w_ext;
    end else begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end
  end

`ifdef DM_ARB_ALIGN_CHECK_EN
  logic r_err;

  always_ff @(posedge clk) begin
    if (clr)
      r_err <= 1'b0;
    else if (r_state == ACCESS)
      r_err <= r_mis;
    else
      r_err <= 1'b0;
  end

  assign m0_err = r_err & r_rvalid0;
  assign m1_err = r_err & r_rvalid1;
`else
  assign m0_err = 1'b0;
  assign m1_err = 1'b0;
`endif

  assign m0_gnt    = w_gnt0;
  assign m1_gnt    = w_gnt1;
  assign m0_rvalid = r_rvalid0;
  assign m1_rvalid = r_rvalid1;
  assign m0_rdata  = r_rdata;
  assign m1_rdata  = r_rdata;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter: vector table of single transactions plus
// hand sequences for ties, back-to-back grants, clr mid-access and misalignment.
module tb_dm_port_arbiter;

  logic        clk;
  logic        clr;
  logic        m0_req, m0_we, m0_sext, m0_gnt, m0_rvalid, m0_err;
  logic [31:0] m0_addr, m0_wd, m0_rdata;
  logic [1:0]  m0_size;
  logic        m1_req, m1_we, m1_sext, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m1_addr, m1_wd, m1_rdata;
  logic [1:0]  m1_size;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr, dm_wd, dm_rd;
  logic        dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem [0:63];
  logic        mem_wipe;
  logic [32:0] exp_q [$];

  dm_port_arbiter dut (
    .clk(clk), .clr(clr),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wd(m0_wd),
    .m0_size(m0_size), .m0_sext(m0_sext), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wd(m1_wd),
    .m1_size(m1_size), .m1_sext(m1_sext), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata), .m1_err(m1_err),
    .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_rd(dm_rd),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // data memory model: combinational read, byte-enabled write at the edge
  assign dm_rd = mem[dm_addr[7:2]];
  always @(posedge clk) begin
    if (mem_wipe) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
    end else if (dm_we) begin
      for (int b = 0; b < 4; b++)
        if (dm_be[b]) mem[dm_addr[7:2]][b*8 +: 8] <= dm_wd[b*8 +: 8];
    end
  end

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [1:0]  size;
    logic        sext;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, wanted %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic port, input logic req, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [1:0] size, input logic sext);
    if (!port) begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_wd = wd; m0_size = size; m0_sext = sext;
    end else begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_wd = wd; m1_size = size; m1_sext = sext;
    end
  endtask

  task automatic idle_ports();
    m0_req = 1'b0;
    m1_req = 1'b0;
  endtask

  // one isolated transaction: gnt at N, DM access at N+1, response at N+2
  task automatic do_txn(input vec_t v, input string tag);
    @(negedge clk);
    drive(v.port, 1'b1, v.we, v.addr, v.wd, v.size, v.sext);
    #1;
    chk({tag, " gnt"}, {30'h0, m1_gnt, m0_gnt}, v.port ? 32'h2 : 32'h1);
    @(negedge clk);
    idle_ports();
    #1;
    chk({tag, " dm_we"}, {31'h0, dm_we}, {31'h0, v.we});
    chk({tag, " dm_be"}, {28'h0, dm_be}, {28'h0, v.exp_be});
    chk({tag, " dm_addr"}, dm_addr, v.addr);
    if (v.we) chk({tag, " dm_wd"}, dm_wd, v.exp_wd);
    @(negedge clk);
    #1;
    chk({tag, " rvalid"}, {30'h0, m1_rvalid, m0_rvalid}, v.port ? 32'h2 : 32'h1);
    chk({tag, " rdata"}, v.port ? m1_rdata : m0_rdata, v.exp_rdata);
    chk({tag, " err"}, {30'h0, m1_err, m0_err}, 32'h0);
  endtask

  initial begin
    vec_t v;
    // port, we, addr, wd, size, sext, be, dm_wd, rdata
    vecs[0]  = '{1'b0, 1'b0, 32'h00, 32'h0,        2'b10, 1'b0, 4'b1111, 32'h0,        32'h11111111};
    vecs[1]  = '{1'b1, 1'b0, 32'h04, 32'h0,        2'b10, 1'b1, 4'b1111, 32'h0,        32'h22222222};
    vecs[2]  = '{1'b0, 1'b1, 32'h13, 32'h123456AB, 2'b00, 1'b0, 4'b1000, 32'hABABABAB, 32'h0};
    vecs[3]  = '{1'b0, 1'b0, 32'h13, 32'h0,        2'b00, 1'b1, 4'b1000, 32'h0,        32'hFFFFFFAB};
    vecs[4]  = '{1'b1, 1'b0, 32'h13, 32'h0,        2'b00, 1'b0, 4'b1000, 32'h0,        32'h000000AB};
    vecs[5]  = '{1'b1, 1'b1, 32'h22, 32'hFFFF8001, 2'b01, 1'b0, 4'b1100, 32'h80018001, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 32'h22, 32'h0,        2'b01, 1'b1, 4'b1100, 32'h0,        32'hFFFF8001};
    vecs[7]  = '{1'b0, 1'b0, 32'h22, 32'h0,        2'b01, 1'b0, 4'b1100, 32'h0,        32'h00008001};
    vecs[8]  = '{1'b0, 1'b1, 32'h10, 32'h0000007F, 2'b00, 1'b0, 4'b0001, 32'h7F7F7F7F, 32'h0};
    vecs[9]  = '{1'b1, 1'b0, 32'h10, 32'h0,        2'b11, 1'b0, 4'b1111, 32'h0,        32'hAB00007F};
    vecs[10] = '{1'b0, 1'b0, 32'h11, 32'h0,        2'b00, 1'b1, 4'b0010, 32'h0,        32'h00000000};
    vecs[11] = '{1'b1, 1'b0, 32'h12, 32'h0,        2'b01, 1'b0, 4'b1100, 32'h0,        32'h0000AB00};
    vecs[12] = '{1'b0, 1'b0, 32'h10, 32'h0,        2'b01, 1'b1, 4'b0011, 32'h0,        32'h0000007F};

    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    clr = 1'b1;
    mem_wipe = 1'b1;

    // reset state, with a request raised during clr that must not be granted
    @(negedge clk);
    @(negedge clk);
    m0_req = 1'b1;
    #1;
    chk("gnt during clr", {30'h0, m1_gnt, m0_gnt}, 32'h0);
    @(negedge clk);
    m0_req = 1'b0;
    clr = 1'b0;
    mem_wipe = 1'b0;
    #1;
    chk("reset state", {31'h0, dbg_state}, 32'h0);
    chk("reset dm_we/be", {27'h0, dm_we, dm_be}, 32'h0);
    chk("reset dm_addr", dm_addr, 32'h0);
    chk("reset dm_wd", dm_wd, 32'h0);
    chk("reset rvalid/err", {28'h0, m1_rvalid, m0_rvalid, m1_err, m0_err}, 32'h0);
    chk("reset rdata", m0_rdata, 32'h0);

    // tie after reset: port 0 first, then port 1
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 32'h0, 32'h11111111, 2'b10, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 32'h4, 32'h22222222, 2'b10, 1'b0);
    #1;
    chk("tie gnt c1", {30'h0, m1_gnt, m0_gnt}, 32'h1);
    @(negedge clk);
    m0_req = 1'b0;
    #1;
    chk("tie gnt c2", {30'h0, m1_gnt, m0_gnt}, 32'h2);
    chk("tie acc0 be", {27'h0, dm_we, dm_be}, 32'h1F);
    chk("tie acc0 wd", dm_wd, 32'h11111111);
    @(negedge clk);
    m1_req = 1'b0;
    #1;
    chk("tie rvalid0", {30'h0, m1_rvalid, m0_rvalid}, 32'h1);
    chk("tie acc1 addr", dm_addr, 32'h4);
    chk("tie acc1 wd", dm_wd, 32'h22222222);
    @(negedge clk);
    #1;
    chk("tie rvalid1", {30'h0, m1_rvalid, m0_rvalid}, 32'h2);
    chk("mem word0", mem[0], 32'h11111111);
    chk("mem word1", mem[1], 32'h22222222);

    for (int i = 0; i < 13; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

    // both ports requesting for 6 cycles from a fresh reset: strict alternation
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 2'b10, 1'b0);
    for (int k = 0; k < 8; k++) begin
      logic [32:0] e;
      if (k > 0) @(negedge clk);
      if (k == 6) idle_ports();
      #1;
      if (k < 6) begin
        chk($sformatf("alt gnt%0d", k), {30'h0, m1_gnt, m0_gnt}, (k % 2 == 0) ? 32'h1 : 32'h2);
        exp_q.push_back((k % 2 == 0) ? {1'b0, 32'h11111111} : {1'b1, 32'h22222222});
      end
      if (k >= 2) begin
        e = exp_q.pop_front();
        chk($sformatf("alt rvalid%0d", k - 2), {30'h0, m1_rvalid, m0_rvalid}, e[32] ? 32'h2 : 32'h1);
        chk($sformatf("alt rdata%0d", k - 2), e[32] ? m1_rdata : m0_rdata, e[31:0]);
      end
    end

    // clr in the access cycle of a store: no write, no response
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 2'b10, 1'b0);
    #1;
    chk("clr sw gnt", {30'h0, m1_gnt, m0_gnt}, 32'h1);
    @(negedge clk);
    m0_req = 1'b0;
    clr = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
    #1;
    chk("clr dm_we", {31'h0, dm_we}, 32'h0);
    chk("clr gnt void", {30'h0, m1_gnt, m0_gnt}, 32'h0);
    @(negedge clk);
    clr = 1'b0;
    m1_req = 1'b0;
    #1;
    chk("clr no rvalid a", {30'h0, m1_rvalid, m0_rvalid}, 32'h0);
    chk("clr state idle", {31'h0, dbg_state}, 32'h0);
    @(negedge clk);
    #1;
    chk("clr no rvalid b", {30'h0, m1_rvalid, m0_rvalid}, 32'h0);
    chk("clr mem 0x40", mem[16], 32'h0);
    v = '{1'b1, 1'b0, 32'h40, 32'h0, 2'b10, 1'b0, 4'b1111, 32'h0, 32'h0};
    do_txn(v, "lw after clr");

    // misaligned word store and half load
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 32'h42, 32'hCAFEF00D, 2'b10, 1'b0);
    #1;
    chk("mis sw gnt", {30'h0, m1_gnt, m0_gnt}, 32'h2);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'h23, 32'h0, 2'b01, 1'b1);
    m1_req = 1'b0;
    #1;
`ifdef DM_ARB_ALIGN_CHECK_EN
    chk("mis sw dm", {27'h0, dm_we, dm_be}, 32'h00);
`else
    chk("mis sw dm", {27'h0, dm_we, dm_be}, 32'h1F);
`endif
    chk("mis lh gnt", {30'h0, m1_gnt, m0_gnt}, 32'h1);
    @(negedge clk);
    m0_req = 1'b0;
    #1;
    chk("mis sw rvalid", {30'h0, m1_rvalid, m0_rvalid}, 32'h2);
    chk("mis sw rdata", m1_rdata, 32'h0);
`ifdef DM_ARB_ALIGN_CHECK_EN
    chk("mis sw err", {31'h0, m1_err}, 32'h1);
    chk("mis lh dm_be", {28'h0, dm_be}, 32'h0);
`else
    chk("mis sw err", {31'h0, m1_err}, 32'h0);
    chk("mis lh dm_be", {28'h0, dm_be}, 32'hC);
`endif
    @(negedge clk);
    #1;
    chk("mis lh rvalid", {30'h0, m1_rvalid, m0_rvalid}, 32'h1);
`ifdef DM_ARB_ALIGN_CHECK_EN
    chk("mis lh err", {31'h0, m0_err}, 32'h1);
    chk("mis lh rdata", m0_rdata, 32'h0);
    chk("mis mem 0x40", mem[16], 32'h0);
`else
    chk("mis lh err", {31'h0, m0_err}, 32'h0);
    chk("mis lh rdata", m0_rdata, 32'hFFFF8001);
    chk("mis mem 0x40", mem[16], 32'hCAFEF00D);
`endif

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
